// File: rtl/ahb2_arbiter.sv
// AMBA2 AHB bus arbiter for NUM_MST masters: round-robin grant that is held across
// fixed-length bursts and locked sequences, with registered grant, owner and lock outputs.
module ahb2_arbiter #(
    parameter  int NUM_MST     = 4,
    parameter  int DEFAULT_MST = 0,
    localparam int MST_W       = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hreset_n,
    input  logic [NUM_MST-1:0] hbusreq_i,
    input  logic [NUM_MST-1:0] hlock_i,
    input  logic [1:0]         htrans_i,
    input  logic [2:0]         hburst_i,
    input  logic               hready_i,
    input  logic [1:0]         hresp_i,
    output logic [NUM_MST-1:0] hgrant_o,
    output logic [MST_W-1:0]   hmaster_o,
    output logic               hmastlock_o
);

    localparam int PW = MST_W + 1;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_BUSY    = 2'b01;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic [NUM_MST-1:0] GRANT_ONE = NUM_MST'(1);
    localparam logic [NUM_MST-1:0] GRANT_RST = GRANT_ONE << DEFAULT_MST;

    logic [MST_W-1:0] grant_idx;
    logic [MST_W-1:0] winner;
    logic [MST_W-1:0] rr_ptr;
    logic [PW-1:0]    pos;
    logic             found;
    logic             lock_hold;
    logic             arb_ok;
    logic [4:0]       beat_cnt;
    logic [4:0]       beat_nxt;

    // Remaining beats after the NONSEQ of a fixed-length burst; SINGLE/INCR are open-ended.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: burst_beats = 5'd3;
            3'd4, 3'd5: burst_beats = 5'd7;
            3'd6, 3'd7: burst_beats = 5'd15;
            default:    burst_beats = 5'd0;
        endcase
    endfunction

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (hgrant_o[k]) grant_idx = MST_W'(k);
        end
    end

    // Round-robin search starting just after rr_ptr and wrapping back onto rr_ptr itself.
    always_comb begin
        winner = MST_W'(DEFAULT_MST);
        found  = 1'b0;
        pos    = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            pos = {1'b0, rr_ptr} + PW'(i);
            if (pos >= PW'(NUM_MST)) pos = pos - PW'(NUM_MST);
            if (!found && hbusreq_i[pos[MST_W-1:0]]) begin
                found  = 1'b1;
                winner = pos[MST_W-1:0];
            end
        end
    end

    always_comb begin
        beat_nxt = beat_cnt;
        if (hresp_i != RESP_OKAY) begin
            beat_nxt = '0;
        end else if (hready_i) begin
            case (htrans_i)
                TR_IDLE:   beat_nxt = '0;
                TR_BUSY:   beat_nxt = beat_cnt;
                TR_NONSEQ: beat_nxt = burst_beats(hburst_i);
                TR_SEQ:    if (beat_cnt != '0) beat_nxt = beat_cnt - 5'd1;
                default:   beat_nxt = beat_cnt;
            endcase
        end
    end

    // hmastlock_o keeps the grant one transfer past hlock deassertion; RETRY/SPLIT break any hold.
    assign lock_hold = hlock_i[grant_idx] || hmastlock_o;
    assign arb_ok    = ((beat_cnt <= 5'd1) && !lock_hold)
                       || (hresp_i == RESP_RETRY) || (hresp_i == RESP_SPLIT);

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            hgrant_o    <= GRANT_RST;
            hmaster_o   <= MST_W'(DEFAULT_MST);
            hmastlock_o <= 1'b0;
            beat_cnt    <= '0;
            rr_ptr      <= MST_W'(DEFAULT_MST);
        end else begin
            beat_cnt <= beat_nxt;
            if (hready_i) begin
                hmaster_o   <= grant_idx;
                hmastlock_o <= hlock_i[grant_idx];
            end
            if (arb_ok) begin
                hgrant_o <= GRANT_ONE << winner;
                if (winner != grant_idx) rr_ptr <= winner;
            end
        end
    end

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Scoreboard bench for ahb2_arbiter (NUM_MST=4, DEFAULT_MST=0): a cycle model pushes the
// expected grant/owner/lock/beat count per edge, popped and compared one cycle later.
module tb_ahb2_arbiter;

    localparam int N  = 4;
    localparam int D  = 0;
    localparam int MW = 2;

    logic          hclk = 1'b0;
    logic          hreset_n;
    logic [N-1:0]  hbusreq_i;
    logic [N-1:0]  hlock_i;
    logic [1:0]    htrans_i;
    logic [2:0]    hburst_i;
    logic          hready_i;
    logic [1:0]    hresp_i;
    logic [N-1:0]  hgrant_o;
    logic [MW-1:0] hmaster_o;
    logic          hmastlock_o;

    ahb2_arbiter #(.NUM_MST(N), .DEFAULT_MST(D)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hbusreq_i(hbusreq_i), .hlock_i(hlock_i),
        .htrans_i(htrans_i), .hburst_i(hburst_i), .hready_i(hready_i), .hresp_i(hresp_i),
        .hgrant_o(hgrant_o), .hmaster_o(hmaster_o), .hmastlock_o(hmastlock_o)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [N-1:0]  g;
        logic [MW-1:0] m;
        logic          l;
        logic [4:0]    c;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference state: granted index, owner, lock flag, remaining beats, round-robin pointer.
    int mg, mm, ml, mc, mr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mg = D; mm = D; ml = 0; mc = 0; mr = D;
    endtask

    function automatic int beats_of(input logic [2:0] b);
        if (b == 3'd2 || b == 3'd3) return 3;
        if (b == 3'd4 || b == 3'd5) return 7;
        if (b == 3'd6 || b == 3'd7) return 15;
        return 0;
    endfunction

    task automatic model_step();
        int   w, ng, nr, nm, nl, nc;
        bit   ok, any;
        exp_t e;
        ok = (mc <= 1) && !(hlock_i[mg[MW-1:0]] || ml != 0);
        if (hresp_i == 2'b10 || hresp_i == 2'b11) ok = 1;
        w = D; any = 0;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (mr + i) % N;
            if (!any && hbusreq_i[k[MW-1:0]]) begin any = 1; w = k; end
        end
        ng = mg; nr = mr;
        if (ok) begin
            ng = w;
            if (w != mg) nr = w;
        end
        nm = mm; nl = ml;
        if (hready_i) begin nm = mg; nl = int'(hlock_i[mg[MW-1:0]]); end
        nc = mc;
        if (hresp_i != 2'b00) nc = 0;
        else if (hready_i) begin
            if (htrans_i == 2'b00) nc = 0;
            else if (htrans_i == 2'b10) nc = beats_of(hburst_i);
            else if (htrans_i == 2'b11 && mc > 0) nc = mc - 1;
        end
        mg = ng; mr = nr; mm = nm; ml = nl; mc = nc;
        e.g = '0;
        e.g[mg[MW-1:0]] = 1'b1;
        e.m = mm[MW-1:0];
        e.l = ml[0];
        e.c = mc[4:0];
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_step();
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("grant",  32'(hgrant_o),     32'(e.g));
            check("master", 32'(hmaster_o),    32'(e.m));
            check("lock",   32'(hmastlock_o),  32'(e.l));
            check("beats",  32'(dut.beat_cnt), 32'(e.c));
        end
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
        hbusreq_i = req; hlock_i = lck; htrans_i = tr; hburst_i = bu; hready_i = rdy; hresp_i = rsp;
    endtask

    logic [N-1:0] rot [4];

    initial begin
        rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;
        hreset_n = 1'b0;
        drive(4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        check("rst_grant",  32'(hgrant_o),     32'h1);
        check("rst_master", 32'(hmaster_o),    32'h0);
        check("rst_lock",   32'(hmastlock_o),  32'h0);
        hreset_n = 1'b1;

        // Round-robin rotation with everyone requesting SINGLE transfers
        drive(4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_rot", 32'(hgrant_o), 32'(rot[i]));
        end

        // INCR8 by M2; M1 starts requesting after the NONSEQ
        drive(4'b0100, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step(); step();
        check("m2_owner", 32'(hmaster_o), 32'd2);
        drive(4'b0100, 4'b0000, 2'b10, 3'd5, 1'b1, 2'b00);
        step();
        drive(4'b0110, 4'b0000, 2'b11, 3'd5, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            step();
            check("incr8_hold", 32'(hgrant_o), 32'h4);
        end
        step();
        check("incr8_move", 32'(hgrant_o), 32'h2);
        drive(4'b0010, 4'b0000, 2'b10, 3'd0, 1'b1, 2'b00);
        step();
        check("incr8_own", 32'(hmaster_o), 32'd1);

        // INCR4 by M1 with three wait states mid-burst, M0 waiting
        drive(4'b0010, 4'b0000, 2'b10, 3'd3, 1'b1, 2'b00);
        step();
        drive(4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 2'b00);
        step();
        hready_i = 1'b0;
        repeat (3) step();
        check("wait_hold", 32'(hgrant_o), 32'h2);
        hready_i = 1'b1;
        step(); step();
        check("incr4_move", 32'(hgrant_o), 32'h1);

        // Locked sequence by M3 with all others requesting, then release
        drive(4'b1000, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step();
        drive(4'b1111, 4'b1000, 2'b10, 3'd0, 1'b1, 2'b00);
        repeat (5) step();
        check("lock_hold", 32'(hgrant_o), 32'h8);
        check("lock_flag", 32'(hmastlock_o), 32'h1);
        hlock_i = 4'b0000;
        step();
        check("lock_tail", 32'(hgrant_o), 32'h8);
        step();
        check("lock_rel", 32'(hgrant_o), 32'h1);

        // RETRY in the middle of a locked sequence forces re-arbitration
        drive(4'b1000, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step();
        drive(4'b1111, 4'b1000, 2'b10, 3'd0, 1'b1, 2'b00);
        step(); step();
        drive(4'b1111, 4'b1000, 2'b10, 3'd0, 1'b0, 2'b10);
        step();
        check("retry_move", 32'(hgrant_o), 32'h1);
        drive(4'b0001, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step(); step();

        // ERROR on beat 2 of an INCR16 by M2, then IDLE
        drive(4'b0100, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step(); step();
        drive(4'b0100, 4'b0000, 2'b10, 3'd7, 1'b1, 2'b00);
        step();
        drive(4'b0111, 4'b0000, 2'b11, 3'd7, 1'b1, 2'b00);
        step();
        drive(4'b0111, 4'b0000, 2'b11, 3'd7, 1'b0, 2'b01);
        step();
        check("err_cnt", 32'(dut.beat_cnt), 32'd0);
        drive(4'b0111, 4'b0000, 2'b00, 3'd7, 1'b1, 2'b01);
        step();
        check("err_move", 32'(hgrant_o), 32'h1);
        drive(4'b0111, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step();

        // Parking on the default master when nobody requests
        drive(4'b0010, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step();
        drive(4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 2'b00);
        step();
        check("park", 32'(hgrant_o), 32'h1);

        // Asynchronous reset in the middle of a locked burst
        drive(4'b0100, 4'b0100, 2'b00, 3'd0, 1'b1, 2'b00);
        step();
        drive(4'b0110, 4'b0100, 2'b10, 3'd5, 1'b1, 2'b00);
        step();
        htrans_i = 2'b11;
        step();
        hreset_n = 1'b0;
        #2;
        check("arst_grant",  32'(hgrant_o),     32'h1);
        check("arst_master", 32'(hmaster_o),    32'h0);
        check("arst_lock",   32'(hmastlock_o),  32'h0);
        check("arst_beats",  32'(dut.beat_cnt), 32'h0);
        model_reset();
        #2;
        hreset_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            hbusreq_i = 4'($urandom);
            hlock_i   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            htrans_i  = 2'($urandom);
            hburst_i  = 3'($urandom);
            hready_i  = ($urandom_range(0, 3) != 0);
            hresp_i   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            step();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
